// File: rtl/fetch_decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_decode_queue_pkg
// Brief  : Shared fetch/decode pipeline widths, NOP encoding, entry layout
// Rev    : 1.0  initial release
// ============================================================================
package fetch_decode_queue_pkg;

  localparam int unsigned c_addr_w  = 20;
  localparam int unsigned c_instr_w = 16;

  localparam logic [c_instr_w-1:0] c_nop_instr = 16'h0000;

  // Entry layout as seen by the fetch and decode stages.
  typedef struct packed {
    logic [c_addr_w-1:0]  pc;
    logic [c_instr_w-1:0] instr;
  } entry_t;

endpackage : fetch_decode_queue_pkg
`default_nettype wire

// File: rtl/fetch_decode_queue_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : queue_ptr_ctrl
// Brief  : Read/write pointers, occupancy and full/empty for a 2^n queue
// Rev    : 1.0  initial release
// ============================================================================
module queue_ptr_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_req,
  input  logic                       pop_req,
  output logic                       push,
  output logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [PW:0] c_one = {{PW{1'b0}}, 1'b1};

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  logic [PW:0] r_count;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = push_req & ~w_full;
  assign w_pop   = pop_req & ~w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign push   = w_push;
  assign pop    = w_pop;
  assign full   = w_full;
  assign empty  = w_empty;
  assign wr_idx = r_wr_ptr[PW-1:0];
  assign rd_idx = r_rd_ptr[PW-1:0];
  assign count  = r_count;

endmodule : queue_ptr_ctrl
`default_nettype wire

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_decode_queue
// Brief  : {pc, instr} decoupling queue between fetch and decode, with flush
// Rev    : 1.0  initial release
// ============================================================================
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned ADDR_W  = c_addr_w,
  parameter int unsigned INSTR_W = c_instr_w,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     f_valid,
  input  logic [ADDR_W-1:0]        f_pc,
  input  logic [INSTR_W-1:0]       f_instr,
  output logic                     f_ready,
  output logic                     d_valid,
  output logic [ADDR_W-1:0]        d_pc,
  output logic [INSTR_W-1:0]       d_instr,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [INSTR_W-1:0] c_nop = INSTR_W'(c_nop_instr);

  logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;
  logic [PW:0]   w_count;

  queue_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .push_req (f_valid),
    .pop_req  (d_ready),
    .push     (w_push),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .wr_idx   (w_wr_idx),
    .rd_idx   (w_rd_idx),
    .count    (w_count)
  );

  // Storage is deliberately left unreset; occupancy tracking gates its use.
  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_mem_pc[w_wr_idx]    <= f_pc;
      r_mem_instr[w_wr_idx] <= f_instr;
    end
  end

  assign f_ready = ~w_full;
  assign d_valid = ~w_empty;
  assign d_pc    = w_empty ? '0    : r_mem_pc[w_rd_idx];
  assign d_instr = w_empty ? c_nop : r_mem_instr[w_rd_idx];
  assign count   = w_count;

endmodule : fetch_decode_queue
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_decode_queue
// Brief  : Directed self-checking bench for fetch_decode_queue
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_decode_queue;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 4;

  logic               clock;
  logic               reset;
  logic               flush;
  logic               f_valid;
  logic [ADDR_W-1:0]  f_pc;
  logic [INSTR_W-1:0] f_instr;
  logic               f_ready;
  logic               d_valid;
  logic [ADDR_W-1:0]  d_pc;
  logic [INSTR_W-1:0] d_instr;
  logic               d_ready;
  logic [2:0]         count;

  int n_compared;
  int n_mismatched;

  fetch_decode_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .f_valid (f_valid),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .f_ready (f_ready),
    .d_valid (d_valid),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .d_ready (d_ready),
    .count   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs applied before the edge take effect on it; sampling happens 1ns after.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] pc);
    f_valid = 1'b1;
    f_pc    = pc;
    f_instr = 16'hA000 + pc[15:0];
    tick();
    f_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset   = 1'b0;
    flush   = 1'b0;
    f_valid = 1'b1;
    f_pc    = 20'h00123;
    f_instr = 16'h5555;
    d_ready = 1'b0;

    // 1: reset held with f_valid asserted
    tick();
    tick();
    check_eq("rst_f_ready", f_ready, 1);
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_d_instr", d_instr, 0);
    check_eq("rst_d_pc",    d_pc,    0);
    check_eq("rst_count",   count,   0);
    f_valid = 1'b0;
    reset   = 1'b1;
    tick();
    check_eq("rst_no_write", count, 0);

    // 2: fill
    for (int i = 0; i < 4; i++) begin
      push_one(ADDR_W'(i));
      check_eq($sformatf("fill_count%0d", i), count, i + 1);
    end
    check_eq("fill_f_ready", f_ready, 0);
    check_eq("fill_d_valid", d_valid, 1);
    check_eq("fill_d_pc",    d_pc,    0);
    check_eq("fill_d_instr", d_instr, 32'hA000);

    // push attempt while full is held off
    push_one(20'h00099);
    check_eq("full_hold_count", count, 4);
    check_eq("full_hold_d_pc",  d_pc,  0);

    // 3: drain
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain_d_pc%0d", i),    d_pc,    i);
      check_eq($sformatf("drain_d_instr%0d", i), d_instr, 32'hA000 + i);
      tick();
    end
    check_eq("drain_d_valid", d_valid, 0);
    check_eq("drain_count",   count,   0);
    check_eq("drain_d_instr_nop", d_instr, 0);
    tick();
    check_eq("empty_pop_count", count, 0);
    d_ready = 1'b0;

    // full queue refuses push even with a concurrent pop
    for (int i = 0; i < 4; i++) push_one(ADDR_W'(40 + i));
    f_valid = 1'b1;
    f_pc    = 20'h00077;
    f_instr = 16'h7777;
    d_ready = 1'b1;
    tick();
    f_valid = 1'b0;
    d_ready = 1'b0;
    check_eq("full_pop_count", count, 3);
    check_eq("full_pop_d_pc",  d_pc,  41);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("full_pop_order%0d", i), d_pc, 41 + i);
      d_ready = 1'b1;
      tick();
    end
    d_ready = 1'b0;
    check_eq("full_pop_empty", d_valid, 0);

    // 4: concurrent push/pop across pointer wrap
    push_one(20'd100);
    push_one(20'd101);
    check_eq("conc_start_count", count, 2);
    for (int i = 0; i < 10; i++) begin
      f_valid = 1'b1;
      f_pc    = ADDR_W'(102 + i);
      f_instr = 16'hA000 + 16'(102 + i);
      d_ready = 1'b1;
      check_eq($sformatf("conc_d_pc%0d", i), d_pc, 100 + i);
      tick();
      check_eq($sformatf("conc_count%0d", i), count, 2);
    end
    f_valid = 1'b0;
    check_eq("conc_tail0", d_pc, 110);
    tick();
    check_eq("conc_tail1", d_pc, 111);
    tick();
    d_ready = 1'b0;
    check_eq("conc_end_count", count, 0);

    // 5: flush with concurrent push and pop
    for (int i = 0; i < 3; i++) push_one(ADDR_W'(200 + i));
    check_eq("flush_pre_count", count, 3);
    flush   = 1'b1;
    f_valid = 1'b1;
    f_pc    = 20'h00300;
    f_instr = 16'h3000;
    d_ready = 1'b1;
    #1;
    check_eq("flush_f_ready", f_ready, 1);
    tick();
    flush   = 1'b0;
    f_valid = 1'b0;
    d_ready = 1'b0;
    check_eq("flush_count",   count,   0);
    check_eq("flush_d_valid", d_valid, 0);
    f_valid = 1'b1;
    f_pc    = 20'h00F1F;
    f_instr = 16'hBEEF;
    tick();
    f_valid = 1'b0;
    check_eq("post_flush_d_pc",    d_pc,    20'h00F1F);
    check_eq("post_flush_d_instr", d_instr, 16'hBEEF);
    check_eq("post_flush_count",   count,   1);

    // 6: asynchronous reset between edges
    push_one(20'd500);
    push_one(20'd501);
    check_eq("async_pre_count", count, 3);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_count",   count,   0);
    check_eq("async_d_valid", d_valid, 0);
    check_eq("async_d_pc",    d_pc,    0);
    #1;
    reset   = 1'b1;
    f_valid = 1'b1;
    f_pc    = 20'h00055;
    f_instr = 16'h0055;
    tick();
    f_valid = 1'b0;
    check_eq("rel_count", count, 1);
    check_eq("rel_d_pc",  d_pc,  20'h00055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_fetch_decode_queue
`default_nettype wire
